audio_i2s_tx: RTL

- Audio output end of the sound path: generates the sample-rate strobe `aud_valid` that the sound playout logic consumes, and accepts the `audio` sample it returns.
- Serializes each sample onto a standard Philips I2S link (BCLK, LRCLK, SDATA) for the external DAC Pmod. The same mono sample goes on both channels.
- All outputs are derived from `clk` by counters; no clock-domain crossing. MCLK is generated elsewhere, not by this block.

---
 rtl/sound_pkg.sv | 29 ++
 rtl/audio_i2s_timing.sv | 78 +++++++
 rtl/audio_i2s_tx.sv | 73 +++++++
 3 files changed

// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_pkg
// Purpose  : Shared constants and sample formatting for the sound output path.
// Revision : 1.0 - initial release
// ============================================================================
package sound_pkg;

    localparam int I2S_SLOT_BITS     = 16;
    localparam int I2S_BCLK_HALF_DIV = 4;

    // Offset-binary input becomes two's complement by flipping its MSB;
    // the result is then left-justified so the DAC sees full-scale range.
    function automatic logic [31:0] aud_to_slot(
        input logic [31:0] aud,
        input int          aud_bits,
        input int          slot_bits,
        input logic        signed_in
    );
        logic [31:0] v;
        v = aud;
        if (!signed_in) begin
            v = v ^ (32'd1 << (aud_bits - 1));
        end
        return v << (slot_bits - aud_bits);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_i2s_timing.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_timing
// Purpose  : I2S frame counters; generates BCLK, LRCLK and data strobes.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_timing #(
    parameter int SLOT_BITS     = 16,
    parameter int BCLK_HALF_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    output logic bclk_o,
    output logic lrclk_o,
    output logic aud_valid_o,
    output logic load_stb_o,
    output logic shift_stb_o
);

    localparam int HALF_CNT = 4 * SLOT_BITS;
    localparam int DIV_W    = $clog2(BCLK_HALF_DIV);
    localparam int HALF_W   = $clog2(HALF_CNT);

    localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(BCLK_HALF_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(HALF_CNT - 1);
    localparam logic [HALF_W-1:0] HALF_LOAD  = HALF_W'(1);
    localparam logic [HALF_W-1:0] HALF_RIGHT = HALF_W'(2 * SLOT_BITS);

    logic              run;
    logic              div_wrap;
    logic [DIV_W-1:0]  div_q,  div_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic              bclk_q;
    logic              lrclk_q;

    assign run      = enable_i & ~reset;
    assign div_wrap = (div_q == DIV_LAST);

    always_comb begin
        div_d  = div_q;
        half_d = half_q;
        if (!run) begin
            div_d  = '0;
            half_d = '0;
        end else if (div_wrap) begin
            div_d  = '0;
            half_d = (half_q == HALF_LAST) ? '0 : half_q + 1'b1;
        end else begin
            div_d  = div_q + 1'b1;
        end
    end

    // Outputs are registered from the next-state counters so every edge of
    // BCLK, LRCLK and the data path lands on the same clk edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            half_q  <= '0;
            bclk_q  <= 1'b0;
            lrclk_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            half_q  <= half_d;
            bclk_q  <= half_d[0];
            lrclk_q <= (half_d >= HALF_RIGHT);
        end
    end

    // Strobes fire in the cycle whose closing edge is a BCLK falling edge.
    assign load_stb_o  = run & div_wrap & (half_q == HALF_LOAD);
    assign shift_stb_o = run & div_wrap & half_q[0] & (half_q != HALF_LOAD);
    assign aud_valid_o = run & (half_q == '0) & (div_q == '0);
    assign bclk_o      = bclk_q;
    assign lrclk_o     = lrclk_q;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : audio_i2s_tx
// Purpose  : Mono sample to Philips I2S serializer with sample-rate strobe.
// Revision : 1.0 - initial release
// ============================================================================
module audio_i2s_tx
    import sound_pkg::*;
#(
    parameter int AUD_BITS      = 12,
    parameter int SLOT_BITS     = I2S_SLOT_BITS,
    parameter int BCLK_HALF_DIV = I2S_BCLK_HALF_DIV,
    parameter int SIGNED_IN     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                mute,
    input  logic [AUD_BITS-1:0] audio,
    output logic                aud_valid,
    output logic                i2s_bclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata
);

    localparam int SHIFT_W = 2 * SLOT_BITS;

    logic                 load_stb;
    logic                 shift_stb;
    logic [SLOT_BITS-1:0] slot;
    logic [SHIFT_W-1:0]   shift_q, shift_d;
    logic                 sdata_q;

    audio_i2s_timing #(
        .SLOT_BITS     (SLOT_BITS),
        .BCLK_HALF_DIV (BCLK_HALF_DIV)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .bclk_o      (i2s_bclk),
        .lrclk_o     (i2s_lrclk),
        .aud_valid_o (aud_valid),
        .load_stb_o  (load_stb),
        .shift_stb_o (shift_stb)
    );

    assign slot = mute ? '0
                : SLOT_BITS'(aud_to_slot(32'(audio), AUD_BITS, SLOT_BITS, SIGNED_IN != 0));

    always_comb begin
        shift_d = shift_q;
        if (load_stb) begin
            shift_d = {slot, slot};
        end else if (shift_stb) begin
            shift_d = {shift_q[SHIFT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            shift_q <= '0;
            sdata_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            sdata_q <= shift_d[SHIFT_W-1];
        end
    end

    assign i2s_sdata = sdata_q;

endmodule
`default_nettype wire
